// File: rtl/h14tx_pattern_gen_pkg.sv
// Shared types and constants for the h14tx test-pattern source.
package h14tx_pattern_gen_pkg;

    typedef enum logic [2:0] {
        PAT_SOLID    = 3'd0,
        PAT_BARS     = 3'd1,
        PAT_CHECKER  = 3'd2,
        PAT_GRADIENT = 3'd3,
        PAT_BOX      = 3'd4
    } pattern_mode_e;

    // [2]=R, [1]=G, [0]=B
    typedef logic [2:0][7:0] rgb_t;

    localparam rgb_t RGB_BLACK = 24'h000000;
    localparam rgb_t RGB_WHITE = 24'hFFFFFF;

    // Colour bars, left to right.
    localparam rgb_t BAR_COLOURS [8] = '{
        24'hFFFFFF,   // white
        24'hFFFF00,   // yellow
        24'h00FFFF,   // cyan
        24'h00FF00,   // green
        24'hFF00FF,   // magenta
        24'hFF0000,   // red
        24'h0000FF,   // blue
        24'h000000    // black
    };

endpackage

// File: rtl/h14tx_pattern_gen_bouncer.sv
// One axis of the bouncing box: position plus travel direction, stepped once per frame.
//
// dir_up | meaning
// -------+------------------------------------------------
//   1    | moving towards Limit, pos grows by Step per frame
//   0    | moving towards 0, pos shrinks by Step per frame
module h14tx_bouncer #(
    parameter int Width = 11,
    parameter int Limit = 1216,
    parameter int Step  = 4
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    input  logic             step_en,
    output logic [Width-1:0] pos
);

    localparam logic [Width:0] LIMIT_W = (Width+1)'(Limit);
    localparam logic [Width:0] STEP_W  = (Width+1)'(Step);

    logic           dir_up;
    logic [Width:0] pos_w;

    // One extra bit so pos+Step cannot wrap before the compare.
    assign pos_w = {1'b0, pos};

    // Advance one step per frame, clamping at each end and reversing there.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            pos    <= '0;
            dir_up <= 1'b1;
        end else if (step_en) begin
            if (dir_up) begin
                if (pos_w + STEP_W >= LIMIT_W) begin
                    pos    <= Width'(Limit);
                    dir_up <= 1'b0;
                end else begin
                    pos <= pos + Width'(Step);
                end
            end else begin
                if (pos_w <= STEP_W) begin
                    pos    <= '0;
                    dir_up <= 1'b1;
                end else begin
                    pos <= pos - Width'(Step);
                end
            end
        end
    end

endmodule

// File: rtl/h14tx_pattern_gen.sv
// Test-pattern source for h14tx_rgb: maps the published x/y to a registered RGB pixel.
// Mode, frame counter and box position only change at the frame-start pixel.
module h14tx_pattern_gen
    import h14tx_pattern_gen_pkg::*;
#(
    parameter int BitWidth     = 11,
    parameter int BitHeight    = 10,
    parameter int ActiveWidth  = 1280,
    parameter int ActiveHeight = 720,
    parameter int BoxSize      = 64,
    parameter int Step         = 4,
    parameter int CheckLog2    = 5
) (
    input  logic                 pixel_clk,
    input  logic                 rst_n,
    input  logic [2:0]           mode,
    input  rgb_t                 solid_rgb,
    input  logic [BitWidth-1:0]  x,
    input  logic [BitHeight-1:0] y,
    output rgb_t                 rgb,
    output logic [7:0]           frame_cnt
);

    logic                 origin;
    logic                 origin_q;
    logic                 fs;
    logic [2:0]           mode_q;
    logic [BitWidth-1:0]  bx;
    logic [BitHeight-1:0] by;
    logic [BitWidth:0]    x_w;
    logic [BitHeight:0]   y_w;
    logic                 active;
    logic                 in_box;
    logic [2:0]           bar_idx;
    rgb_t                 pix_next;

    assign origin = (x == '0) && (y == '0);
    // Only the first cycle of a held origin counts as a frame start.
    assign fs     = origin && !origin_q;

    assign x_w    = {1'b0, x};
    assign y_w    = {1'b0, y};
    assign active = (x_w < (BitWidth+1)'(ActiveWidth)) && (y_w < (BitHeight+1)'(ActiveHeight));

    assign in_box = (x_w >= {1'b0, bx}) && (x_w < {1'b0, bx} + (BitWidth+1)'(BoxSize)) &&
                    (y_w >= {1'b0, by}) && (y_w < {1'b0, by} + (BitHeight+1)'(BoxSize));

    h14tx_bouncer #(
        .Width (BitWidth),
        .Limit (ActiveWidth - BoxSize),
        .Step  (Step)
    ) u_bounce_x (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .step_en   (fs),
        .pos       (bx)
    );

    h14tx_bouncer #(
        .Width (BitHeight),
        .Limit (ActiveHeight - BoxSize),
        .Step  (Step)
    ) u_bounce_y (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .step_en   (fs),
        .pos       (by)
    );

    // Bar index from constant boundaries k*ActiveWidth/8; no divider in hardware.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (x_w >= (BitWidth+1)'(k * ActiveWidth / 8)) begin
                bar_idx = 3'(k);
            end
        end
    end

    // Next pixel from the current coordinate and the pre-update frame state.
    always_comb begin
        pix_next = RGB_BLACK;
        if (active) begin
            case (mode_q)
                PAT_SOLID:    pix_next = solid_rgb;
                PAT_BARS:     pix_next = BAR_COLOURS[bar_idx];
                PAT_CHECKER:  pix_next = (x[CheckLog2] ^ y[CheckLog2]) ? RGB_WHITE : RGB_BLACK;
                PAT_GRADIENT: pix_next = {x[7:0], y[7:0], frame_cnt};
                PAT_BOX:      pix_next = in_box ? RGB_WHITE : solid_rgb;
                default:      pix_next = RGB_BLACK;
            endcase
        end
    end

    // Output register plus per-frame state latched on frame start.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            rgb       <= RGB_BLACK;
            frame_cnt <= '0;
            mode_q    <= PAT_SOLID;
            origin_q  <= 1'b0;
        end else begin
            rgb      <= pix_next;
            origin_q <= origin;
            if (fs) begin
                mode_q    <= mode;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_h14tx_pattern_gen.sv
// Directed bench for h14tx_pattern_gen with hand-derived pixel and counter values.
module tb_h14tx_pattern_gen;
    import h14tx_pattern_gen_pkg::*;

    localparam logic [23:0] SOLID  = 24'h0C2238;
    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] BLACK  = 24'h000000;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] BLUE   = 24'h0000FF;

    logic        pixel_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic [2:0]  mode      = 3'd0;
    rgb_t        solid_rgb;
    logic [10:0] x;
    logic [9:0]  y;
    rgb_t        rgb;
    logic [7:0]  frame_cnt;

    int total = 0;
    int bad   = 0;
    int nfs   = 0;
    int bx_m  = 0;
    int by_m  = 0;
    bit dx_m  = 1'b1;
    bit dy_m  = 1'b1;

    always #5 pixel_clk = ~pixel_clk;

    h14tx_pattern_gen dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .solid_rgb (solid_rgb),
        .x         (x),
        .y         (y),
        .rgb       (rgb),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present a coordinate, then look at the registered output 1 ns after the edge.
    task automatic drive(input int xi, input int yi);
        x = 11'(xi);
        y = 10'(yi);
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic pix(input string tag, input int xi, input int yi, input logic [23:0] exp);
        drive(xi, yi);
        chk(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic step_axis(inout int p, inout bit up, input int lim);
        if (up) begin
            if (p + 4 >= lim) begin p = lim; up = 1'b0; end
            else p = p + 4;
        end else begin
            if (p <= 4) begin p = 0; up = 1'b1; end
            else p = p - 4;
        end
    endtask

    // Leave the origin, then hit it once: one frame start.
    task automatic frame();
        drive(1, 1);
        drive(0, 0);
        nfs++;
        step_axis(bx_m, dx_m, 1216);
        step_axis(by_m, dy_m, 656);
        chk("frame_cnt", 32'(frame_cnt), 32'(nfs % 256));
    endtask

    task automatic model_reset();
        nfs  = 0;
        bx_m = 0;
        by_m = 0;
        dx_m = 1'b1;
        dy_m = 1'b1;
    endtask

    initial begin
        solid_rgb = SOLID;
        x = 11'd5;
        y = 10'd5;
        rst_n = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("rst_rgb", 32'(rgb), 32'(BLACK));
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Solid colour and blanking.
        frame();
        chk("solid_origin", 32'(rgb), 32'(SOLID));
        chk("first_fs_cnt", 32'(frame_cnt), 32'd1);
        pix("solid_mid", 640, 360, SOLID);
        pix("solid_last", 1279, 719, SOLID);
        pix("blank_x", 1280, 0, BLACK);
        pix("blank_y", 0, 720, BLACK);
        pix("blank_corner", 1649, 749, BLACK);

        // Colour bars; the origin still renders with the previous mode.
        mode = 3'd1;
        frame();
        chk("bars_origin_old", 32'(rgb), 32'(SOLID));
        pix("bar_159", 159, 10, WHITE);
        pix("bar_160", 160, 10, YELLOW);
        pix("bar_1119", 1119, 10, BLUE);
        pix("bar_1120", 1120, 10, BLACK);
        pix("bar_1279", 1279, 10, BLACK);

        // Mid-frame request for checker: bars hold until the next origin.
        mode = 3'd2;
        pix("bars_hold_500", 500, 300, GREEN);
        pix("bars_hold_1279", 1279, 719, BLACK);
        frame();
        chk("checker_origin_old", 32'(rgb), 32'(WHITE));
        pix("chk_32_0", 32, 0, WHITE);
        pix("chk_32_32", 32, 32, BLACK);
        pix("chk_0_32", 0, 32, WHITE);

        // Gradient: R=x[7:0], G=y[7:0], B=frame_cnt (4 here).
        mode = 3'd3;
        frame();
        pix("grad_300_200", 300, 200, 24'h2CC804);
        pix("grad_511_255", 511, 255, 24'hFFFF04);

        // Bouncing box over many frames.
        mode = 3'd4;
        frame();
        while (nfs <= 310) begin
            pix("box_in", bx_m, by_m, WHITE);
            pix("box_right", bx_m + 64, by_m, (bx_m + 64 >= 1280) ? BLACK : SOLID);
            if (by_m > 0) pix("box_above", bx_m, by_m - 1, SOLID);
            if (nfs == 164) begin
                pix("by_656_in", bx_m, 656, WHITE);
                pix("by_656_above", bx_m, 655, SOLID);
                pix("by_656_bottom", bx_m, 719, WHITE);
            end
            if (nfs == 165) pix("by_652_in", bx_m, 652, WHITE);
            if (nfs == 304) begin
                pix("bx_1216_in", 1216, by_m, WHITE);
                pix("bx_1216_left", 1215, by_m, SOLID);
                pix("bx_1216_right", 1279, by_m, WHITE);
            end
            if (nfs == 305) begin
                pix("bx_1212_in", 1212, by_m, WHITE);
                pix("bx_1212_left", 1211, by_m, SOLID);
                pix("bx_1212_end", 1276, by_m, SOLID);
            end
            frame();
        end

        // Held origin gives exactly one frame start.
        drive(1, 1);
        repeat (5) drive(0, 0);
        nfs++;
        step_axis(bx_m, dx_m, 1216);
        step_axis(by_m, dy_m, 656);
        chk("hold_once", 32'(frame_cnt), 32'(nfs % 256));

        // One-cycle reset mid-frame.
        drive(700, 400);
        rst_n = 1'b0;
        drive(700, 400);
        chk("midrst_rgb", 32'(rgb), 32'(BLACK));
        chk("midrst_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        model_reset();
        frame();
        chk("postrst_origin", 32'(rgb), 32'(SOLID));
        chk("postrst_cnt", 32'(frame_cnt), 32'd1);
        pix("postrst_box_4_4", 4, 4, WHITE);
        pix("postrst_box_3_4", 3, 4, SOLID);
        pix("postrst_box_4_3", 4, 3, SOLID);
        pix("postrst_box_67", 67, 67, WHITE);
        pix("postrst_box_68", 68, 4, SOLID);

        // Unassigned code renders black; then frame counter wrap.
        mode = 3'd6;
        frame();
        pix("mode6_mid", 100, 100, BLACK);
        pix("mode6_last", 1279, 719, BLACK);
        while (nfs < 256) frame();
        chk("wrap_0", 32'(frame_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
